// File: rtl/mem_responder.sv
// CPU-facing memory responder: loads program RAM from a byte stream after reset, then
// services single CPU reads/writes and I/O reads against an external synchronous RAM.
module mem_responder #(
  parameter int unsigned ADDR_W       = 16,
  parameter logic [7:0]  IO_IDLE_DATA = 8'hFF
) (
  input  logic              clk,
  input  logic              n_reset,
  // CPU strobes, all active-low
  input  logic              mem_n_pmem,
  input  logic              mem_n_m1,
  input  logic              mem_n_mreq,
  input  logic              mem_n_rd,
  input  logic              mem_n_wr,
  input  logic              io_n_iorq,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dout,
  input  logic              mem_dout_en,
  output logic [7:0]        mem_din,
  output logic              ipram_loaded,
  // Program loader stream
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic              ram_sel,
  input  logic [7:0]        ram_rdata,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    StLoad,
    StIdle,
    StRdWait,
    StRdCap,
    StWr
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              loaded_q, loaded_d;
  logic              load_ready_q, load_ready_d;
  logic              bus_err_q, bus_err_d;
  logic              rd_req_q, wr_req_q;

  logic rd_req, wr_req, io_rd, proto_err, rd_start, wr_start;

  assign rd_req = !mem_n_mreq && !mem_n_rd && mem_n_wr;
  assign wr_req = !mem_n_mreq && !mem_n_wr && mem_n_rd && mem_dout_en;
  assign io_rd  = !io_n_iorq && mem_n_mreq && !mem_n_rd;

  assign proto_err = (!mem_n_mreq && !mem_n_rd && !mem_n_wr) ||
                     (!mem_n_mreq && !io_n_iorq) ||
                     (!mem_n_m1 && mem_n_pmem);

  // Request history is tracked in every state so edges seen while busy are consumed, not queued.
  assign rd_start = rd_req && !rd_req_q && !proto_err;
  assign wr_start = wr_req && !wr_req_q && !proto_err;

  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    mem_din_d    = mem_din_q;
    loaded_d     = loaded_q;
    load_ready_d = 1'b0;
    bus_err_d    = bus_err_q;
    ram_addr     = '0;
    ram_wdata    = 8'h00;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_sel      = 1'b0;

    if (state_q != StLoad && proto_err) begin
      bus_err_d = 1'b1;
    end

    case (state_q)
      StLoad: begin
        load_ready_d = 1'b1;
        if (load_ready_q && load_valid) begin
          ram_we     = 1'b1;
          ram_addr   = load_ptr_q;
          ram_wdata  = load_data;
          load_ptr_d = load_ptr_q + 1'b1;
          if (load_last || (&load_ptr_q)) begin
            state_d      = StIdle;
            loaded_d     = 1'b1;
            load_ready_d = 1'b0;
          end
        end
      end
      StIdle: begin
        if (rd_start) begin
          ram_re   = 1'b1;
          ram_addr = mem_addr;
          ram_sel  = mem_n_pmem;
          state_d  = StRdWait;
        end else if (wr_start) begin
          ram_we    = 1'b1;
          ram_addr  = mem_addr;
          ram_wdata = mem_dout;
          ram_sel   = mem_n_pmem;
          state_d   = StWr;
        end else if (io_rd && !proto_err) begin
          mem_din_d = IO_IDLE_DATA;
        end
      end
      StRdWait: begin
        mem_din_d = ram_rdata;
        state_d   = StRdCap;
      end
      StRdCap: state_d = StIdle;
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= StLoad;
      load_ptr_q   <= '0;
      mem_din_q    <= 8'h00;
      loaded_q     <= 1'b0;
      load_ready_q <= 1'b0;
      bus_err_q    <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      mem_din_q    <= mem_din_d;
      loaded_q     <= loaded_d;
      load_ready_q <= load_ready_d;
      bus_err_q    <= bus_err_d;
      rd_req_q     <= rd_req;
      wr_req_q     <= wr_req;
    end
  end

  assign mem_din      = mem_din_q;
  assign ipram_loaded = loaded_q;
  assign load_ready   = load_ready_q;
  assign bus_err      = bus_err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: ADDR_W, 16, width of the CPU and RAM address buses.
REQ-002 Parameter: IO_IDLE_DATA, 8'hFF, value driven on mem_din for I/O cycles.
REQ-003 Port: clk  input  1  single clock; all logic is on the rising edge.
REQ-004 Port: n_reset  input  1  asynchronous, active-low reset.
REQ-005 Ports, CPU strobes (all active-low): mem_n_pmem, mem_n_m1, mem_n_mreq, mem_n_rd, mem_n_wr, io_n_iorq; each input, 1 bit.
REQ-006 Port: mem_addr  input  ADDR_W  CPU address.
REQ-007 Port: mem_dout  input  8  CPU write data; mem_dout_en  input  1  CPU write data valid.
REQ-008 Port: mem_din  output  8  registered read data to CPU.
REQ-009 Port: ipram_loaded  output  1  high once the program-RAM load has completed.
REQ-010 Loader ports: load_valid input 1; load_data input 8; load_last input 1; load_ready output 1 (valid/ready byte handshake).
REQ-011 RAM ports: ram_addr output ADDR_W; ram_wdata output 8; ram_we output 1; ram_re output 1; ram_sel output 1 (0 = program RAM, 1 = data RAM); ram_rdata input 8, valid one cycle after ram_re.
REQ-012 Port: bus_err  output  1  sticky protocol-error flag.

Function
REQ-013 States SHALL be LOAD, IDLE, RD_WAIT, RD_CAP and WR.
REQ-014 LOAD: load_ready=1; each cycle with load_valid=1 SHALL issue ram_we=1, ram_sel=0, ram_addr=load pointer, ram_wdata=load_data, and increment the pointer.
REQ-015 A handshake byte with load_last=1, or a byte written at pointer all-ones, SHALL end LOAD; next cycle state=IDLE, ipram_loaded=1, load_ready=0.
REQ-016 After LOAD, ipram_loaded SHALL stay 1 until reset; load_valid SHALL be ignored.
REQ-017 All CPU strobes SHALL be ignored in LOAD; no CPU access SHALL be issued or queued.
REQ-018 Read request = mem_n_mreq=0 and mem_n_rd=0 and mem_n_wr=1; write request = mem_n_mreq=0 and mem_n_wr=0 and mem_n_rd=1 and mem_dout_en=1.
REQ-019 A request SHALL start an access only on the first cycle it is sampled true after being false; a held strobe SHALL produce exactly one access.
REQ-020 IDLE + read start: same cycle ram_re=1, ram_addr=mem_addr, ram_sel=mem_n_pmem; -> RD_WAIT.
REQ-021 RD_WAIT -> RD_CAP: mem_din loads ram_rdata; mem_din valid 2 cycles after the strobe is first sampled; -> IDLE next cycle.
REQ-022 mem_din SHALL hold its last value until the next read capture or I/O cycle.
REQ-023 IDLE + write start: same cycle ram_we=1, ram_addr=mem_addr, ram_wdata=mem_dout, ram_sel=mem_n_pmem; -> WR for one cycle, then IDLE.
REQ-024 ram_we and ram_re SHALL be single-cycle pulses and never asserted together.
REQ-025 New request edges arriving in RD_WAIT, RD_CAP or WR SHALL be dropped, not queued.
REQ-026 io_n_iorq=0 with mem_n_mreq=1 and mem_n_rd=0 SHALL, one cycle later, load mem_din with IO_IDLE_DATA and issue no RAM access.
REQ-027 mem_n_mreq=0 with mem_n_rd=0 and mem_n_wr=0, or mem_n_mreq=0 and io_n_iorq=0, SHALL set bus_err=1 and issue no access.
REQ-028 mem_n_m1 SHALL only qualify reads: mem_n_m1=0 together with mem_n_pmem=1 SHALL set bus_err.
REQ-029 Addresses SHALL pass through unmodified; no wrap or offset arithmetic on CPU accesses.

Reset
REQ-030 n_reset=0 SHALL asynchronously force: state=LOAD, load pointer=0, mem_din=8'h00, ipram_loaded=0, load_ready=0 while n_reset=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, ram_sel=0, bus_err=0.
REQ-031 Reset mid-load or mid-access SHALL abort it; the loader SHALL restart at address 0 after release.
REQ-032 load_ready SHALL first rise on the first clock after n_reset deasserts.

Verification
REQ-033 Load 3 bytes 11,22,33 with last on 33 -> ram_we at addr 0,1,2, sel 0; ipram_loaded=1 the cycle after byte 33.
REQ-034 Read with mem_n_pmem=1, addr 16'h8000, RAM returns 8'hA5 -> single ram_re, sel 1; mem_din=8'hA5 two cycles after the strobe.
REQ-035 Write held 4 cycles, addr 16'h0100, data 8'h3C -> exactly one ram_we pulse, wdata 8'h3C.
REQ-036 I/O read with io_n_iorq=0 -> no RAM strobe; mem_din=8'hFF.
REQ-037 mem_n_rd=mem_n_wr=0 under mreq -> bus_err=1 sticky, no RAM strobe; reset clears it.
REQ-038 Reset asserted during the second load byte -> pointer=0, ipram_loaded=0; the reload starts at address 0.
